// File: rtl/ccr_unit.sv
// Condition-code register {C,N,Z} with jump resolution and a small LIFO
// shadow stack that saves flags on interrupt entry and restores them on RTI.
module ccr_unit #(
  parameter int SHADOW_DEPTH = 2,
  parameter int CW           = $clog2(SHADOW_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          alu_valid,
  input  logic [2:0]    alu_flag_we,
  input  logic [2:0]    alu_flags,
  input  logic          setc,
  input  logic          clrc,
  input  logic          jmp_resolve,
  input  logic [1:0]    jmp_cond,
  output logic          jmp_taken,
  input  logic          int_save,
  input  logic          rti_restore,
  output logic [2:0]    ccr,
  output logic [CW-1:0] shadow_count,
  output logic          shadow_full,
  output logic          shadow_empty,
  output logic          err
);
  localparam logic [CW-1:0] DEPTH_C = CW'(SHADOW_DEPTH);

  logic [2:0] shadow [SHADOW_DEPTH];
  logic [2:0] next_flags;
  logic [2:0] top_entry;

  assign shadow_full  = (shadow_count == DEPTH_C);
  assign shadow_empty = (shadow_count == '0);

  // Decision uses only the committed flags; no forwarding from this cycle.
  always_comb begin
    jmp_taken = 1'b0;
    if (jmp_resolve) begin
      case (jmp_cond)
        2'b00:   jmp_taken = 1'b1;
        2'b01:   jmp_taken = ccr[0];
        2'b10:   jmp_taken = ccr[1];
        default: jmp_taken = ccr[2];
      endcase
    end
  end

  // Normal update: jump clear, then ALU write, then clrc, then setc.
  always_comb begin
    next_flags = ccr;
    if (jmp_taken) begin
      case (jmp_cond)
        2'b01:   next_flags[0] = 1'b0;
        2'b10:   next_flags[1] = 1'b0;
        2'b11:   next_flags[2] = 1'b0;
        default: next_flags = ccr;
      endcase
    end
    if (alu_valid)
      next_flags = (next_flags & ~alu_flag_we) | (alu_flags & alu_flag_we);
    if (clrc)
      next_flags[2] = 1'b0;
    if (setc)
      next_flags[2] = 1'b1;
  end

  always_comb begin
    top_entry = 3'b000;
    for (int i = 0; i < SHADOW_DEPTH; i++)
      if (shadow_count == CW'(i + 1))
        top_entry = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr          <= 3'b000;
      shadow_count <= '0;
      err          <= 1'b0;
      for (int i = 0; i < SHADOW_DEPTH; i++)
        shadow[i] <= 3'b000;
    end else if (!stall) begin
      if (int_save && rti_restore) begin
        err <= 1'b1;
        ccr <= next_flags;
      end else if (rti_restore) begin
        if (shadow_empty) begin
          err <= 1'b1;
          ccr <= next_flags;
        end else begin
          ccr          <= top_entry;
          shadow_count <= shadow_count - CW'(1);
        end
      end else begin
        ccr <= next_flags;
        if (int_save) begin
          if (shadow_full) begin
            err <= 1'b1;
          end else begin
            for (int i = 0; i < SHADOW_DEPTH; i++)
              if (shadow_count == CW'(i))
                shadow[i] <= ccr;
            shadow_count <= shadow_count + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: directed scenarios plus random traffic, all checked
// against a flag/stack model built on a queue.
module tb_ccr_unit;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, stall, alu_valid, setc, clrc, jmp_resolve;
  logic [2:0]    alu_flag_we, alu_flags;
  logic [1:0]    jmp_cond;
  logic          jmp_taken, int_save, rti_restore;
  logic [2:0]    ccr;
  logic [CW-1:0] shadow_count;
  logic          shadow_full, shadow_empty, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];   // {err, full, empty, count[3:0], ccr}
  logic [2:0] m_ccr = 3'b000;
  logic [2:0] m_stk[$];
  logic       m_err = 1'b0;
  logic       last_jt;

  always #5 clk = ~clk;

  ccr_unit #(.SHADOW_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_valid(alu_valid),
    .alu_flag_we(alu_flag_we), .alu_flags(alu_flags), .setc(setc), .clrc(clrc),
    .jmp_resolve(jmp_resolve), .jmp_cond(jmp_cond), .jmp_taken(jmp_taken),
    .int_save(int_save), .rti_restore(rti_restore), .ccr(ccr),
    .shadow_count(shadow_count), .shadow_full(shadow_full),
    .shadow_empty(shadow_empty), .err(err)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_jt();
    int k = int'(jmp_cond);
    if (!jmp_resolve) return 1'b0;
    if (k == 0) return 1'b1;
    return m_ccr[k-1];
  endfunction

  task automatic model_edge();
    logic [2:0] nf;
    int k;
    if (rst) begin
      m_ccr = 3'b000;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!stall) begin
      nf = m_ccr;
      k  = int'(jmp_cond);
      if (model_jt() && k != 0) nf[k-1] = 1'b0;
      for (int b = 0; b < 3; b++)
        if (alu_valid && alu_flag_we[b]) nf[b] = alu_flags[b];
      if (clrc) nf[2] = 1'b0;
      if (setc) nf[2] = 1'b1;
      if (int_save && rti_restore) begin
        m_err = 1'b1;
        m_ccr = nf;
      end else if (rti_restore) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_ccr = nf;
        end else begin
          m_ccr = m_stk.pop_back();
        end
      end else begin
        if (int_save) begin
          if (m_stk.size() == DEPTH) m_err = 1'b1;
          else m_stk.push_back(m_ccr);
        end
        m_ccr = nf;
      end
    end
    exp_q.push_back({m_err, m_stk.size() == DEPTH, m_stk.size() == 0,
                     4'(m_stk.size()), m_ccr});
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic tick();
    logic [9:0] e;
    #1;
    last_jt = jmp_taken;
    check("jmp_taken", jmp_taken, model_jt());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check("ccr",   ccr,          e[2:0]);
    check("count", shadow_count, e[6:3]);
    check("empty", shadow_empty, e[7]);
    check("full",  shadow_full,  e[8]);
    check("err",   err,          e[9]);
  endtask

  task automatic idle();
    rst = 0; stall = 0; alu_valid = 0; alu_flag_we = 0; alu_flags = 0;
    setc = 0; clrc = 0; jmp_resolve = 0; jmp_cond = 0;
    int_save = 0; rti_restore = 0;
  endtask

  task automatic do_rst();
    idle(); rst = 1; tick();
  endtask

  task automatic alu(logic [2:0] we, logic [2:0] fl);
    idle(); alu_valid = 1; alu_flag_we = we; alu_flags = fl; tick();
  endtask

  task automatic op_save();
    idle(); int_save = 1; tick();
  endtask

  task automatic op_restore();
    idle(); rti_restore = 1; tick();
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_rst();
    check("rst_ccr", ccr, 3'b000);
    check("rst_empty", shadow_empty, 1'b1);
    check("rst_err", err, 1'b0);

    // Flag-to-jump latency and taken JZ clearing Z
    alu(3'b011, 3'b001);
    check("alu_z", ccr, 3'b001);
    idle(); jmp_resolve = 1; jmp_cond = 2'b01; tick();
    check("jz_taken", last_jt, 1'b1);
    check("jz_clear", ccr, 3'b000);

    // setc overrides ALU C, then clrc alone
    alu(3'b111, 3'b110);
    idle(); alu_valid = 1; alu_flag_we = 3'b100; alu_flags = 3'b000; setc = 1; tick();
    check("setc_win", ccr, 3'b110);
    idle(); clrc = 1; tick();
    check("clrc", ccr, 3'b010);

    // Nesting to depth, overflow, unwind, underflow
    do_rst();
    alu(3'b111, 3'b101); op_save();
    alu(3'b111, 3'b010); op_save();
    op_save();
    check("ovf_err", err, 1'b1);
    check("ovf_count", shadow_count, 2);
    op_restore();
    check("pop1", ccr, 3'b010);
    op_restore();
    check("pop2", ccr, 3'b101);
    op_restore();
    check("unf_err", err, 1'b1);
    check("unf_count", shadow_count, 0);

    // Restore discards ALU update; then jump sees restored flags
    do_rst();
    alu(3'b111, 3'b011); op_save();
    alu(3'b111, 3'b000);
    idle(); rti_restore = 1; alu_valid = 1; alu_flag_we = 3'b111; alu_flags = 3'b111; tick();
    check("rti_discard", ccr, 3'b011);
    idle(); jmp_resolve = 1; jmp_cond = 2'b10; tick();
    check("jn_after_rti", last_jt, 1'b1);

    // Stall freezes everything, release applies
    do_rst();
    alu(3'b111, 3'b001);
    idle(); stall = 1; alu_valid = 1; alu_flag_we = 3'b111; alu_flags = 3'b010;
    setc = 1; int_save = 1; tick();
    check("stall_ccr", ccr, 3'b001);
    check("stall_count", shadow_count, 0);
    stall = 0; tick();
    check("unstall_ccr", ccr, 3'b110);
    check("unstall_count", shadow_count, 1);

    // Reset beats simultaneous save/restore
    do_rst();
    alu(3'b111, 3'b101); op_save();
    idle(); rst = 1; int_save = 1; rti_restore = 1; tick();
    check("rst_mid_count", shadow_count, 0);
    check("rst_mid_ccr", ccr, 3'b000);
    check("rst_mid_err", err, 1'b0);

    // Random traffic
    repeat (800) begin
      rst         = ($urandom_range(0, 63) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      alu_valid   = $urandom_range(0, 1);
      alu_flag_we = 3'($urandom_range(0, 7));
      alu_flags   = 3'($urandom_range(0, 7));
      setc        = ($urandom_range(0, 5) == 0);
      clrc        = ($urandom_range(0, 5) == 0);
      jmp_resolve = $urandom_range(0, 1);
      jmp_cond    = 2'($urandom_range(0, 3));
      int_save    = ($urandom_range(0, 4) == 0);
      rti_restore = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
